collision_scanner: RTL and testbench

Reads the packed obstacle buses produced by the map generator and decides, once per frame, whether the player sprite overlaps any obstacle. On a frame tick it snapshots the player position and all obstacle slots, then walks the slots sequentially, one per clock. It reports hit, the lowest hitting slot index and a done pulse to the game-logic FSM. It is the consumer end of the map → game-logic obstacle interface.

---
 rtl/collision_scanner.sv | 142 ++++++++++++++
 tb/tb_collision_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// collision_scanner: snapshots the player and obstacle slots on a frame tick, then tests one slot per clock for overlap.
// Optional feature macro: COLLISION_EARLY_EXIT_EN (finish the scan at the first overlapping slot).
module collision_scanner #(
   parameter int N_OBS    = 20,
   parameter int PLAYER_X = 100,
   parameter int PLAYER_W = 32,
   parameter int PLAYER_H = 32,
   parameter int OBS_W    = 40,
   parameter int OBS_H    = 60
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic [9:0]           player_y,
   input  logic [10*N_OBS-1:0]  obstacle_x,
   input  logic [9*N_OBS-1:0]   obstacle_y,
   output logic                 busy,
   output logic                 done,
   output logic                 hit,
   output logic [4:0]           hit_index
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_SCAN  = 2'd1;
   localparam logic [1:0]  S_DONE  = 2'd2;
   localparam logic [4:0]  LAST_IDX = 5'(N_OBS - 1);
   localparam logic [9:0]  EMPTY_X  = 10'h3FF;
   localparam logic [10:0] X_LEFT   = 11'(PLAYER_X);
   localparam logic [10:0] X_RIGHT  = 11'(PLAYER_X + PLAYER_W);
   localparam logic [10:0] OW       = 11'(OBS_W);
   localparam logic [10:0] OH       = 11'(OBS_H);
   localparam logic [10:0] PH       = 11'(PLAYER_H);

   logic [1:0]  state_q, state_d;
   logic [4:0]  index_q, index_d;
   logic        hit_flag_q, hit_flag_d;
   logic [4:0]  first_idx_q, first_idx_d;
   logic        hit_q, hit_d;
   logic [4:0]  hit_index_q, hit_index_d;
   logic [9:0]  py_q, py_d;
   logic [9:0]  ox_q [N_OBS];
   logic [9:0]  ox_d [N_OBS];
   logic [8:0]  oy_q [N_OBS];
   logic [8:0]  oy_d [N_OBS];

   logic [10:0] ox_e, oy_e, py_e;
   logic        slot_hit, last_slot, finish;

   // Overlap test on 11-bit zero-extended operands so sums never wrap.
   always_comb begin
      ox_e     = {1'b0, ox_q[index_q]};
      oy_e     = {2'b0, oy_q[index_q]};
      py_e     = {1'b0, py_q};
      slot_hit = (ox_q[index_q] != EMPTY_X)
              && (ox_e < X_RIGHT)
              && ((ox_e + OW) > X_LEFT)
              && (oy_e < (py_e + PH))
              && ((oy_e + OH) > py_e);
      last_slot = (index_q == LAST_IDX);
`ifdef COLLISION_EARLY_EXIT_EN
      finish = last_slot || slot_hit;
`else
      finish = last_slot;
`endif
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      hit_flag_d  = hit_flag_q;
      first_idx_d = first_idx_q;
      hit_d       = hit_q;
      hit_index_d = hit_index_q;
      py_d        = py_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick) begin
               py_d = player_y;
               for (int i = 0; i < N_OBS; i++) begin
                  ox_d[i] = obstacle_x[10*i +: 10];
                  oy_d[i] = obstacle_y[9*i +: 9];
               end
               index_d    = '0;
               hit_flag_d = 1'b0;
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            if (slot_hit && !hit_flag_q) begin
               first_idx_d = index_q;
            end
            hit_flag_d = hit_flag_q | slot_hit;
            index_d    = index_q + 5'd1;
            if (finish) begin
               // Results are published on the same edge that enters DONE.
               hit_d       = hit_flag_d;
               hit_index_d = hit_flag_d ? first_idx_d : 5'd0;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         hit_flag_q  <= 1'b0;
         first_idx_q <= '0;
         hit_q       <= 1'b0;
         hit_index_q <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         hit_flag_q  <= hit_flag_d;
         first_idx_q <= first_idx_d;
         hit_q       <= hit_d;
         hit_index_q <= hit_index_d;
      end
   end

   // Snapshot storage is pure datapath; it is only read while a scan is active.
   always_ff @(posedge clk) begin
      py_q <= py_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign hit       = hit_q;
   assign hit_index = hit_index_q;

endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed and randomized frame scans checked against an arithmetic overlap model.
module tb_collision_scanner;

   localparam int N = 20;

   logic            clk = 1'b0;
   logic            rst;
   logic            frame_tick;
   logic [9:0]      player_y;
   logic [10*N-1:0] obstacle_x;
   logic [9*N-1:0]  obstacle_y;
   logic            busy;
   logic            done;
   logic            hit;
   logic [4:0]      hit_index;

   int total = 0;
   int bad   = 0;
   int ox_m [N];
   int oy_m [N];
   int py_m;

   collision_scanner dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .player_y   (player_y),
      .obstacle_x (obstacle_x),
      .obstacle_y (obstacle_y),
      .busy       (busy),
      .done       (done),
      .hit        (hit),
      .hit_index  (hit_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Player box: x in [100,132), y in [py,py+32). Obstacle box: [ox,ox+40) x [oy,oy+60).
   function automatic void ref_model(output bit h, output int idx);
      h   = 1'b0;
      idx = 0;
      for (int i = 0; i < N; i++) begin
         if (ox_m[i] != 1023 &&
             ox_m[i] < 100 + 32 && ox_m[i] + 40 > 100 &&
             oy_m[i] < py_m + 32 && oy_m[i] + 60 > py_m) begin
            if (!h) idx = i;
            h = 1'b1;
         end
      end
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         ox_m[i] = 1023;
         oy_m[i] = 0;
      end
      py_m = 200;
   endtask

   task automatic pack_buses();
      player_y = py_m[9:0];
      for (int i = 0; i < N; i++) begin
         obstacle_x[10*i +: 10] = ox_m[i][9:0];
         obstacle_y[9*i +: 9]   = oy_m[i][8:0];
      end
   endtask

   task automatic scramble_buses();
      player_y = 10'($urandom_range(0, 1023));
      for (int i = 0; i < N; i++) begin
         obstacle_x[10*i +: 10] = 10'($urandom_range(0, 1023));
         obstacle_y[9*i +: 9]   = 9'($urandom_range(0, 511));
      end
   endtask

   task automatic random_model();
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            ox_m[i] = 1023;
            oy_m[i] = int'($urandom_range(0, 511));
         end else begin
            ox_m[i] = int'($urandom_range(0, 300));
            oy_m[i] = int'($urandom_range(0, 511));
         end
      end
      py_m = int'($urandom_range(0, 700));
   endtask

   // Starts a scan in the current cycle (cycle 0) and returns after sampling cycle done+1.
   task automatic run_scan(input string tag, input int tick_a, input int tick_b, input bit scramble);
      bit   eh;
      int   ei, exp_done, done_at, done_cnt, busy_err;
      logic h_obs, h_hold;
      logic [4:0] i_obs;
      ref_model(eh, ei);
`ifdef COLLISION_EARLY_EXIT_EN
      exp_done = eh ? ei + 2 : N + 1;
`else
      exp_done = N + 1;
`endif
      pack_buses();
      frame_tick = 1'b1;
      done_at = -1; done_cnt = 0; busy_err = 0;
      h_obs = 1'bx; i_obs = 5'bx; h_hold = 1'bx;
      for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
         @(posedge clk); #1;
         frame_tick = (cyc == tick_a || cyc == tick_b);
         if (scramble) scramble_buses();
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = cyc;
               h_obs   = hit;
               i_obs   = hit_index;
            end
         end
         if (busy !== (cyc <= exp_done)) busy_err++;
         if (cyc == exp_done + 1) h_hold = hit;
      end
      check({tag, ".done_cycle"}, done_at, exp_done);
      check({tag, ".done_count"}, done_cnt, 1);
      check({tag, ".busy_errs"}, busy_err, 0);
      check({tag, ".hit"}, h_obs, eh);
      check({tag, ".hit_index"}, i_obs, eh ? ei : 0);
      check({tag, ".hit_hold"}, h_hold, eh);
   endtask

   initial begin
      int dn, bsy;
      rst = 1'b1;
      frame_tick = 1'b0;
      clear_model();
      pack_buses();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.hit", hit, 0);
      check("reset.hit_index", hit_index, 0);

      clear_model();
      run_scan("empty", -1, -1, 1'b0);

      clear_model(); ox_m[7] = 110; oy_m[7] = 190;
      run_scan("slot7", -1, -1, 1'b0);

      clear_model(); ox_m[3] = 110; oy_m[3] = 200; ox_m[12] = 90; oy_m[12] = 180;
      run_scan("two_hits", -1, -1, 1'b0);

      clear_model(); ox_m[0] = 132; oy_m[0] = 200;
      run_scan("edge_x132", -1, -1, 1'b0);
      ox_m[0] = 131;
      run_scan("edge_x131", -1, -1, 1'b0);
      ox_m[0] = 60;
      run_scan("edge_x60", -1, -1, 1'b0);
      ox_m[0] = 61;
      run_scan("edge_x61", -1, -1, 1'b0);

      clear_model(); ox_m[19] = 110; oy_m[19] = 232;
      run_scan("edge_y232", -1, -1, 1'b0);
      oy_m[19] = 231;
      run_scan("edge_y231", -1, -1, 1'b0);
      oy_m[19] = 140;
      run_scan("edge_y140", -1, -1, 1'b0);
      oy_m[19] = 141;
      run_scan("edge_y141", -1, -1, 1'b0);

      clear_model(); ox_m[7] = 110; oy_m[7] = 190;
      run_scan("retick", 5, N + 1, 1'b0);
      run_scan("chained", -1, -1, 1'b0);

      clear_model(); ox_m[9] = 100; oy_m[9] = 210; ox_m[4] = 500; oy_m[4] = 210;
      run_scan("scramble", -1, -1, 1'b1);

      // Abort a scan that has a pending hit; hit still holds 1 from the previous scan.
      clear_model(); ox_m[15] = 120; oy_m[15] = 210;
      pack_buses();
      frame_tick = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         frame_tick = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.hit", hit, 0);
      check("abort.hit_index", hit_index, 0);
      dn = 0; bsy = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
         if (busy === 1'b1) bsy++;
      end
      check("abort.no_done", dn, 0);
      check("abort.no_busy", bsy, 0);
      run_scan("after_abort", -1, -1, 1'b0);

      for (int r = 0; r < 24; r++) begin
         random_model();
         run_scan($sformatf("rand%0d", r), -1, -1, r[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
